// File: rtl/combat_pkg.sv
// rtl/combat_pkg.sv - attack phase type, player indices and default frame counts
package combat_pkg;

  typedef enum logic [1:0] {
    ATK_IDLE     = 2'd0,
    ATK_STARTUP  = 2'd1,
    ATK_ACTIVE   = 2'd2,
    ATK_RECOVERY = 2'd3
  } atk_phase_t;

  localparam int P1 = 0;
  localparam int P2 = 1;

  localparam int DEF_STARTUP_FRAMES  = 3;
  localparam int DEF_ACTIVE_FRAMES   = 4;
  localparam int DEF_RECOVERY_FRAMES = 8;
  localparam int DEF_CNT_W           = 4;

  // Phase that follows the current one once its frame budget is spent
  function automatic atk_phase_t next_phase(input atk_phase_t cur);
    case (cur)
      ATK_STARTUP: next_phase = ATK_ACTIVE;
      ATK_ACTIVE:  next_phase = ATK_RECOVERY;
      default:     next_phase = ATK_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/attack_timer.sv
// rtl/attack_timer.sv - per-player attack phase sequencer with press buffer and hit-landed flag
module attack_timer
  import combat_pkg::*;
#(
  parameter int STARTUP_FRAMES  = DEF_STARTUP_FRAMES,
  parameter int ACTIVE_FRAMES   = DEF_ACTIVE_FRAMES,
  parameter int RECOVERY_FRAMES = DEF_RECOVERY_FRAMES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       attack_req,
  input  logic       alive,
  input  logic       stun_active,
  input  logic       force_idle,
  input  logic       force_recovery,
  input  logic       set_landed,
  output atk_phase_t phase,
  output logic       hit_landed
);

  localparam logic [CNT_W-1:0] STARTUP_LAST  = CNT_W'(STARTUP_FRAMES - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LAST   = CNT_W'(ACTIVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] RECOVERY_LAST = CNT_W'(RECOVERY_FRAMES - 1);

  logic             req_q;
  logic             buf_q;
  logic             rise;
  logic             last_frame;
  logic [CNT_W-1:0] cnt;

  assign rise = attack_req & ~req_q;

  // Flags the final frame of the current phase
  always_comb begin
    last_frame = 1'b0;
    case (phase)
      ATK_STARTUP:  last_frame = (cnt == STARTUP_LAST);
      ATK_ACTIVE:   last_frame = (cnt == ACTIVE_LAST);
      ATK_RECOVERY: last_frame = (cnt == RECOVERY_LAST);
      default:      last_frame = 1'b0;
    endcase
  end

  // Button history; resets high so a button held through reset is not a press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) req_q <= 1'b1;
    else       req_q <= attack_req;
  end

  // Phase sequencer: forced idle beats forced recovery beats normal frame timing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= ATK_IDLE;
      cnt        <= '0;
      buf_q      <= 1'b0;
      hit_landed <= 1'b0;
    end else if (force_idle || !alive) begin
      phase <= ATK_IDLE;
      cnt   <= '0;
      buf_q <= 1'b0;
    end else if (force_recovery) begin
      phase      <= ATK_RECOVERY;
      cnt        <= '0;
      hit_landed <= 1'b1;
    end else begin
      if (set_landed) hit_landed <= 1'b1;
      if (phase == ATK_IDLE) begin
        if ((rise || buf_q) && !stun_active) begin
          phase      <= ATK_STARTUP;
          cnt        <= '0;
          hit_landed <= 1'b0;
          buf_q      <= 1'b0;
        end
      end else begin
        if (rise) buf_q <= 1'b1;
        if (frame_tick) begin
          if (last_frame) begin
            phase <= next_phase(phase);
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/attack_arbiter.sv
// rtl/attack_arbiter.sv - two-player attack sequencing and got_hit arbitration (optional ATTACK_CLASH_EN)
module attack_arbiter
  import combat_pkg::*;
#(
  parameter int STARTUP_FRAMES  = DEF_STARTUP_FRAMES,
  parameter int ACTIVE_FRAMES   = DEF_ACTIVE_FRAMES,
  parameter int RECOVERY_FRAMES = DEF_RECOVERY_FRAMES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] attack_req,
  input  logic       collision,
  input  logic [1:0] stun_active,
  input  logic [1:0] alive,
  output logic [1:0] got_hit,
  output atk_phase_t phase_p1,
  output atk_phase_t phase_p2,
  output logic       priority_p2
`ifdef ATTACK_CLASH_EN
  ,
  output logic       clash
`endif
);

  logic [1:0] landed;
  logic [1:0] conn;
  logic [1:0] hit_d;
  logic [1:0] landed_d;
  logic [1:0] rec_d;
  logic       toggle;
`ifdef ATTACK_CLASH_EN
  logic       clash_d;
`endif

  assign conn[P1] = (phase_p1 == ATK_ACTIVE) && !landed[P1] && collision &&
                    alive[P2] && !stun_active[P2];
  assign conn[P2] = (phase_p2 == ATK_ACTIVE) && !landed[P2] && collision &&
                    alive[P1] && !stun_active[P1];

  // Decide who is hit this cycle; the victim is also the cancelled attacker in a tie
  always_comb begin
    hit_d    = 2'b00;
    landed_d = 2'b00;
    rec_d    = 2'b00;
    toggle   = 1'b0;
`ifdef ATTACK_CLASH_EN
    clash_d  = 1'b0;
`endif
    case (conn)
      2'b01: begin
        hit_d[P2]    = 1'b1;
        landed_d[P1] = 1'b1;
      end
      2'b10: begin
        hit_d[P1]    = 1'b1;
        landed_d[P2] = 1'b1;
      end
      2'b11: begin
`ifdef ATTACK_CLASH_EN
        rec_d   = 2'b11;
        clash_d = 1'b1;
`else
        if (priority_p2) begin
          hit_d[P1]    = 1'b1;
          landed_d[P2] = 1'b1;
        end else begin
          hit_d[P2]    = 1'b1;
          landed_d[P1] = 1'b1;
        end
        toggle = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Registered hit pulses and round-robin tie-break owner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      got_hit     <= 2'b00;
      priority_p2 <= 1'b0;
    end else begin
      got_hit     <= hit_d;
      priority_p2 <= priority_p2 ^ toggle;
    end
  end

`ifdef ATTACK_CLASH_EN
  // Registered one-cycle clash pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) clash <= 1'b0;
    else       clash <= clash_d;
  end
`endif

  attack_timer #(
    .STARTUP_FRAMES (STARTUP_FRAMES),
    .ACTIVE_FRAMES  (ACTIVE_FRAMES),
    .RECOVERY_FRAMES(RECOVERY_FRAMES),
    .CNT_W          (CNT_W)
  ) u_timer_p1 (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .attack_req    (attack_req[P1]),
    .alive         (alive[P1]),
    .stun_active   (stun_active[P1]),
    .force_idle    (hit_d[P1]),
    .force_recovery(rec_d[P1]),
    .set_landed    (landed_d[P1]),
    .phase         (phase_p1),
    .hit_landed    (landed[P1])
  );

  attack_timer #(
    .STARTUP_FRAMES (STARTUP_FRAMES),
    .ACTIVE_FRAMES  (ACTIVE_FRAMES),
    .RECOVERY_FRAMES(RECOVERY_FRAMES),
    .CNT_W          (CNT_W)
  ) u_timer_p2 (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .attack_req    (attack_req[P2]),
    .alive         (alive[P2]),
    .stun_active   (stun_active[P2]),
    .force_idle    (hit_d[P2]),
    .force_recovery(rec_d[P2]),
    .set_landed    (landed_d[P2]),
    .phase         (phase_p2),
    .hit_landed    (landed[P2])
  );

endmodule

// File: tb/tb_attack_arbiter.sv
// tb/tb_attack_arbiter.sv - self-checking bench for attack_arbiter against a frame-countdown model
module tb_attack_arbiter;
  import combat_pkg::*;

  localparam int SF = 3;
  localparam int AF = 4;
  localparam int RF = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [1:0] attack_req;
  logic       collision;
  logic [1:0] stun_active;
  logic [1:0] alive;
  logic [1:0] got_hit;
  atk_phase_t phase_p1;
  atk_phase_t phase_p2;
  logic       priority_p2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  atk_phase_t m_ph [2];
  int         m_left [2];
  logic       m_buf [2];
  logic       m_landed [2];
  logic       m_prev [2];
  logic [1:0] m_hit;
  logic       m_prio;

  always #5 clk = ~clk;

  attack_arbiter #(
    .STARTUP_FRAMES (SF),
    .ACTIVE_FRAMES  (AF),
    .RECOVERY_FRAMES(RF),
    .CNT_W          (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .attack_req (attack_req),
    .collision  (collision),
    .stun_active(stun_active),
    .alive      (alive),
    .got_hit    (got_hit),
    .phase_p1   (phase_p1),
    .phase_p2   (phase_p2),
    .priority_p2(priority_p2)
  );

  function automatic int frames_of(input atk_phase_t p);
    case (p)
      ATK_STARTUP:  frames_of = SF;
      ATK_ACTIVE:   frames_of = AF;
      ATK_RECOVERY: frames_of = RF;
      default:      frames_of = 0;
    endcase
  endfunction

  function automatic atk_phase_t after(input atk_phase_t p);
    case (p)
      ATK_STARTUP: after = ATK_ACTIVE;
      ATK_ACTIVE:  after = ATK_RECOVERY;
      default:     after = ATK_IDLE;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = ATK_IDLE; m_left[i] = 0; m_buf[i] = 1'b0;
      m_landed[i] = 1'b0; m_prev[i] = 1'b1;
    end
    m_hit = 2'b00;
    m_prio = 1'b0;
  endtask

  task automatic model_step();
    logic [1:0] rise, conn, victim;
    logic toggle;
    for (int i = 0; i < 2; i++) begin
      rise[i] = attack_req[i] & ~m_prev[i];
      conn[i] = (m_ph[i] == ATK_ACTIVE) && !m_landed[i] && collision &&
                alive[1-i] && !stun_active[1-i];
    end
    toggle = 1'b0;
    victim = 2'b00;
    if (conn == 2'b11) begin
      victim = m_prio ? 2'b01 : 2'b10;
      toggle = 1'b1;
    end else if (conn[0]) victim = 2'b10;
    else if (conn[1]) victim = 2'b01;
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = attack_req[i];
      if (victim[i] || !alive[i]) begin
        m_ph[i] = ATK_IDLE; m_left[i] = 0; m_buf[i] = 1'b0;
      end else begin
        if (victim[1-i]) m_landed[i] = 1'b1;
        if (m_ph[i] == ATK_IDLE) begin
          if ((rise[i] || m_buf[i]) && !stun_active[i]) begin
            m_ph[i] = ATK_STARTUP; m_left[i] = SF; m_landed[i] = 1'b0; m_buf[i] = 1'b0;
          end
        end else begin
          if (rise[i]) m_buf[i] = 1'b1;
          if (frame_tick) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
              m_ph[i] = after(m_ph[i]);
              m_left[i] = frames_of(m_ph[i]);
            end
          end
        end
      end
    end
    m_hit = victim;
    if (toggle) m_prio = ~m_prio;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_step();
    #1;
    cyc++;
    frame_tick = (cyc % 4 == 0);
  endtask

  task automatic test_reset();
    reset = 1'b1; attack_req = 2'b00; collision = 1'b0;
    stun_active = 2'b00; alive = 2'b11; frame_tick = 1'b0;
    model_reset();
    tick(); tick();
    n_cmp++;
    if ({got_hit, phase_p1, phase_p2, priority_p2} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_state got=%b required=0000000", {got_hit, phase_p1, phase_p2, priority_p2});
    end
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_single_hit();
    int t_act, t_hit, pulses;
    logic [1:0] hit_val;
    collision = 1'b1; stun_active = 2'b00; alive = 2'b11;
    attack_req = 2'b01; tick(); attack_req = 2'b00;
    n_cmp++;
    if (phase_p1 !== ATK_STARTUP) begin
      n_bad++; $display("FAIL single_start phase_p1=%0d required=%0d", phase_p1, ATK_STARTUP);
    end
    t_act = -1; t_hit = -1; pulses = 0; hit_val = 2'b00;
    for (int k = 0; k < 90; k++) begin
      if (phase_p1 == ATK_ACTIVE && t_act < 0) t_act = k;
      if (got_hit != 2'b00) begin
        pulses++;
        if (t_hit < 0) begin t_hit = k; hit_val = got_hit; end
      end
      n_cmp++;
      if (got_hit !== m_hit || phase_p1 !== m_ph[0] || phase_p2 !== m_ph[1] || priority_p2 !== m_prio) begin
        n_bad++;
        $display("FAIL single_model cyc=%0d got_hit=%b/%b p1=%0d/%0d p2=%0d/%0d prio=%b/%b",
                 cyc, got_hit, m_hit, phase_p1, m_ph[0], phase_p2, m_ph[1], priority_p2, m_prio);
      end
      tick();
    end
    n_cmp++;
    if (t_act < 0 || t_hit != t_act + 1 || hit_val !== 2'b10) begin
      n_bad++; $display("FAIL single_latency act=%0d hit=%0d val=%b required hit=act+1 val=10", t_act, t_hit, hit_val);
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++; $display("FAIL single_pulses got=%0d required=1", pulses);
    end
    n_cmp++;
    if (phase_p1 !== ATK_IDLE) begin
      n_bad++; $display("FAIL single_end phase_p1=%0d required=%0d", phase_p1, ATK_IDLE);
    end
  endtask

  task automatic test_tie();
    logic found;
    collision = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 120 && !(phase_p1 == ATK_IDLE && phase_p2 == ATK_IDLE); k++) tick();
      attack_req = 2'b11; tick(); attack_req = 2'b00;
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
        n_cmp++;
        if (got_hit !== m_hit || phase_p1 !== m_ph[0] || phase_p2 !== m_ph[1] || priority_p2 !== m_prio) begin
          n_bad++;
          $display("FAIL tie_model cyc=%0d got_hit=%b/%b p1=%0d/%0d p2=%0d/%0d prio=%b/%b",
                   cyc, got_hit, m_hit, phase_p1, m_ph[0], phase_p2, m_ph[1], priority_p2, m_prio);
        end
        if (got_hit != 2'b00) found = 1'b1;
        else tick();
      end
      n_cmp++;
      if (r == 0 && (got_hit !== 2'b10 || priority_p2 !== 1'b1 || phase_p2 !== ATK_IDLE)) begin
        n_bad++; $display("FAIL tie_first got_hit=%b prio=%b p2=%0d required 10 1 %0d", got_hit, priority_p2, phase_p2, ATK_IDLE);
      end
      if (r == 1 && (got_hit !== 2'b01 || priority_p2 !== 1'b0 || phase_p1 !== ATK_IDLE)) begin
        n_bad++; $display("FAIL tie_second got_hit=%b prio=%b p1=%0d required 01 0 %0d", got_hit, priority_p2, phase_p1, ATK_IDLE);
      end
    end
    for (int k = 0; k < 120 && !(phase_p1 == ATK_IDLE && phase_p2 == ATK_IDLE); k++) tick();
  endtask

  task automatic test_buffer();
    int t_r, starts, returns;
    logic pending;
    atk_phase_t prev, exp_next;
    collision = 1'b0;
    t_r = -1; starts = 0; returns = 0; pending = 1'b0;
    prev = phase_p1; exp_next = ATK_IDLE;
    for (int k = 0; k < 170; k++) begin
      n_cmp++;
      if (got_hit !== m_hit || phase_p1 !== m_ph[0] || phase_p2 !== m_ph[1] || priority_p2 !== m_prio) begin
        n_bad++;
        $display("FAIL buffer_model cyc=%0d got_hit=%b/%b p1=%0d/%0d p2=%0d/%0d prio=%b/%b",
                 cyc, got_hit, m_hit, phase_p1, m_ph[0], phase_p2, m_ph[1], priority_p2, m_prio);
      end
      if (pending) begin
        n_cmp++;
        if (phase_p1 !== exp_next) begin
          n_bad++; $display("FAIL buffer_after_return ret=%0d phase_p1=%0d required=%0d", returns, phase_p1, exp_next);
        end
        pending = 1'b0;
      end
      if (prev == ATK_RECOVERY && phase_p1 == ATK_IDLE) begin
        returns++;
        pending = 1'b1;
        exp_next = (returns == 1) ? ATK_STARTUP : ATK_IDLE;
      end
      if (prev == ATK_IDLE && phase_p1 == ATK_STARTUP) starts++;
      if (phase_p1 == ATK_RECOVERY && t_r < 0) t_r = k;
      prev = phase_p1;
      attack_req = {1'b0, (k == 0) || (t_r >= 0 && (k == t_r + 16 || k == t_r + 18 || k == t_r + 20))};
      tick();
    end
    n_cmp++;
    if (starts != 2 || returns != 2) begin
      n_bad++; $display("FAIL buffer_count starts=%0d returns=%0d required 2 2", starts, returns);
    end
  endtask

  task automatic test_interrupt();
    atk_phase_t prev_p2;
    logic seen, chk_next;
    collision = 1'b1;
    seen = 1'b0; chk_next = 1'b0; prev_p2 = phase_p2;
    for (int k = 0; k < 100; k++) begin
      n_cmp++;
      if (got_hit !== m_hit || phase_p1 !== m_ph[0] || phase_p2 !== m_ph[1] || priority_p2 !== m_prio) begin
        n_bad++;
        $display("FAIL interrupt_model cyc=%0d got_hit=%b/%b p1=%0d/%0d p2=%0d/%0d prio=%b/%b",
                 cyc, got_hit, m_hit, phase_p1, m_ph[0], phase_p2, m_ph[1], priority_p2, m_prio);
      end
      if (chk_next) begin
        n_cmp++;
        if (phase_p2 !== ATK_IDLE) begin
          n_bad++; $display("FAIL interrupt_buf_cleared phase_p2=%0d required=%0d", phase_p2, ATK_IDLE);
        end
        chk_next = 1'b0;
      end
      if (got_hit == 2'b10 && !seen) begin
        seen = 1'b1; chk_next = 1'b1;
        n_cmp++;
        if (prev_p2 !== ATK_STARTUP || phase_p2 !== ATK_IDLE) begin
          n_bad++; $display("FAIL interrupt_idle prev_p2=%0d phase_p2=%0d required %0d then %0d",
                            prev_p2, phase_p2, ATK_STARTUP, ATK_IDLE);
        end
      end
      prev_p2 = phase_p2;
      attack_req = {(k == 6) || (k == 8), (k == 0)};
      tick();
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL interrupt_seen got=0 required=1");
    end
  endtask

  task automatic test_gating();
    logic any_hit, saw_active;
    collision = 1'b1;
    for (int r = 0; r < 2; r++) begin
      stun_active = (r == 0) ? 2'b10 : 2'b00;
      alive       = (r == 0) ? 2'b11 : 2'b01;
      any_hit = 1'b0; saw_active = 1'b0;
      for (int k = 0; k < 70; k++) begin
        n_cmp++;
        if (got_hit !== m_hit || phase_p1 !== m_ph[0] || phase_p2 !== m_ph[1] || priority_p2 !== m_prio) begin
          n_bad++;
          $display("FAIL gating_model cyc=%0d got_hit=%b/%b p1=%0d/%0d p2=%0d/%0d prio=%b/%b",
                   cyc, got_hit, m_hit, phase_p1, m_ph[0], phase_p2, m_ph[1], priority_p2, m_prio);
        end
        if (got_hit != 2'b00) any_hit = 1'b1;
        if (phase_p1 == ATK_ACTIVE) saw_active = 1'b1;
        attack_req = {1'b0, k == 0};
        tick();
      end
      n_cmp++;
      if (any_hit || !saw_active) begin
        n_bad++; $display("FAIL gating_round%0d any_hit=%b saw_active=%b required 0 1", r, any_hit, saw_active);
      end
    end
    stun_active = 2'b00; alive = 2'b11;
  endtask

  task automatic test_random();
    for (int k = 0; k < 2000; k++) begin
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(0, 5) == 0) attack_req[b] = ~attack_req[b];
        stun_active[b] = ($urandom_range(0, 9) == 0);
        alive[b] = ($urandom_range(0, 40) != 0);
      end
      collision = ($urandom_range(0, 3) != 0);
      tick();
      n_cmp++;
      if (got_hit !== m_hit || phase_p1 !== m_ph[0] || phase_p2 !== m_ph[1] || priority_p2 !== m_prio) begin
        n_bad++;
        $display("FAIL random_model cyc=%0d got_hit=%b/%b p1=%0d/%0d p2=%0d/%0d prio=%b/%b",
                 cyc, got_hit, m_hit, phase_p1, m_ph[0], phase_p2, m_ph[1], priority_p2, m_prio);
      end
    end
    attack_req = 2'b00; collision = 1'b0; stun_active = 2'b00; alive = 2'b11;
    repeat (5) tick();
  endtask

  task automatic test_reset_held();
    attack_req = 2'b01;
    for (int k = 0; k < 100 && phase_p1 != ATK_ACTIVE; k++) tick();
    n_cmp++;
    if (phase_p1 !== ATK_ACTIVE) begin
      n_bad++; $display("FAIL held_reach_active phase_p1=%0d required=%0d", phase_p1, ATK_ACTIVE);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({got_hit, phase_p1, phase_p2, priority_p2} !== 7'd0) begin
      n_bad++; $display("FAIL held_async_reset got=%b required=0000000", {got_hit, phase_p1, phase_p2, priority_p2});
    end
    tick(); tick();
    #2 reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_cmp++;
      if (phase_p1 !== ATK_IDLE || phase_p1 !== m_ph[0]) begin
        n_bad++; $display("FAIL held_no_fire cyc=%0d phase_p1=%0d required=%0d", cyc, phase_p1, ATK_IDLE);
      end
    end
    attack_req = 2'b00; tick();
    attack_req = 2'b01; tick();
    n_cmp++;
    if (phase_p1 !== ATK_STARTUP) begin
      n_bad++; $display("FAIL held_repress phase_p1=%0d required=%0d", phase_p1, ATK_STARTUP);
    end
    attack_req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_tie();
    test_buffer();
    test_interrupt();
    test_gating();
    test_random();
    test_reset_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
